// File: rtl/seg7_scan_mux_if.sv
// Bus bundle for seg7_scan_mux: shadow-file writes, commit, brightness,
// and the registered digit-select/segment outputs to the decoder.
interface seg7_scan_mux_if #(
    parameter int SEL_W = 3
);
    logic             wr_en;
    logic [SEL_W-1:0] wr_addr;
    logic [5:0]       wr_data;
    logic             commit;
    logic [3:0]       bright;
    logic             commit_pend;
    logic [SEL_W-1:0] sel;
    logic [7:0]       seg;
    logic             dec_en;
    logic             frame_tick;

    modport master (
        output wr_en, wr_addr, wr_data, commit, bright,
        input  commit_pend, sel, seg, dec_en, frame_tick
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit, bright,
        output commit_pend, sel, seg, dec_en, frame_tick
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// Multiplexed common-anode 7-segment driver with shadow/active digit files,
// frame-aligned commit and 16-level PWM. Optional: SEG7_LZ_SUPPRESS_EN.
module seg7_scan_mux #(
    parameter int NUM_DIGITS = 8,
    parameter int SEL_W      = 3,
    parameter int SCAN_DIV   = 8192
) (
    input  logic          clk,
    input  logic          rst,
    seg7_scan_mux_if.slave bus
);
    localparam int PW    = $clog2(SCAN_DIV);
    localparam int SUB   = SCAN_DIV / 16;
    localparam int SUB_W = (SUB > 1) ? $clog2(SUB) : 1;
    localparam logic [5:0] ENT_RST = 6'b100000;

    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [3:0]       s_q, s_d;
    logic [SEL_W-1:0] dig_q, dig_d;
    logic [3:0]       bri_q, bri_d;
    logic [SEL_W-1:0] sel_q;
    logic [7:0]       seg_q, seg_d;
    logic             dec_en_q;
    logic             ft_q, ft_d;
    logic             pend_q, pend_d;
    logic [5:0]       shd_q [NUM_DIGITS];
    logic [5:0]       act_q [NUM_DIGITS];

    logic       pcnt_end, dig_end, sub_end, copy, wr_ok, blank_eff;
    logic [5:0] cur;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] r;
        case (h)
            4'h0: r = 7'h40;
            4'h1: r = 7'h79;
            4'h2: r = 7'h24;
            4'h3: r = 7'h30;
            4'h4: r = 7'h19;
            4'h5: r = 7'h12;
            4'h6: r = 7'h02;
            4'h7: r = 7'h78;
            4'h8: r = 7'h00;
            4'h9: r = 7'h18;
            4'hA: r = 7'h08;
            4'hB: r = 7'h03;
            4'hC: r = 7'h46;
            4'hD: r = 7'h21;
            4'hE: r = 7'h06;
            default: r = 7'h0E;
        endcase
        return r;
    endfunction

    assign pcnt_end = (pcnt_q == PW'(SCAN_DIV - 1));
    assign dig_end  = (dig_q == SEL_W'(NUM_DIGITS - 1));
    assign sub_end  = (sub_q == SUB_W'(SUB - 1));
    assign wr_ok    = bus.wr_en && ({1'b0, bus.wr_addr} < (SEL_W + 1)'(NUM_DIGITS));
    assign copy     = ft_q && (pend_q || bus.commit);
    assign cur      = act_q[dig_q];

`ifdef SEG7_LZ_SUPPRESS_EN
    logic [NUM_DIGITS-1:0] supp;

    // Leading run of plain zeros (no dp) from the top digit; digit 0 always shown.
    always_comb begin
        logic lead;
        lead = 1'b1;
        supp = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lead    = lead && (act_q[i][3:0] == 4'h0) && !act_q[i][4];
            supp[i] = lead;
        end
    end

    assign blank_eff = cur[5] | supp[dig_q];
`else
    assign blank_eff = cur[5];
`endif

    always_comb begin
        pcnt_d = pcnt_end ? '0 : pcnt_q + 1'b1;
        dig_d  = dig_q;
        if (pcnt_end) dig_d = dig_end ? '0 : dig_q + 1'b1;
        sub_d  = (pcnt_end || sub_end) ? '0 : sub_q + 1'b1;
        s_d    = s_q;
        if (pcnt_end)     s_d = 4'd0;
        else if (sub_end) s_d = s_q + 4'd1;
        // Registered so the pulse coincides with the last cycle of the last slot.
        ft_d   = (pcnt_d == PW'(SCAN_DIV - 1)) && (dig_d == SEL_W'(NUM_DIGITS - 1));
        pend_d = pend_q;
        if (copy)            pend_d = 1'b0;
        else if (bus.commit) pend_d = 1'b1;
        bri_d  = (pcnt_q == '0) ? bus.bright : bri_q;
        seg_d  = 8'hFF;
        if (!blank_eff && (s_q <= bri_q)) seg_d = {~cur[4], hex7(cur[3:0])};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_q   <= '0;
            sub_q    <= '0;
            s_q      <= 4'd0;
            dig_q    <= '0;
            bri_q    <= 4'd0;
            sel_q    <= '0;
            seg_q    <= 8'hFF;
            dec_en_q <= 1'b0;
            ft_q     <= 1'b0;
            pend_q   <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shd_q[i] <= ENT_RST;
                act_q[i] <= ENT_RST;
            end
        end else begin
            pcnt_q   <= pcnt_d;
            sub_q    <= sub_d;
            s_q      <= s_d;
            dig_q    <= dig_d;
            bri_q    <= bri_d;
            sel_q    <= dig_q;
            seg_q    <= seg_d;
            dec_en_q <= 1'b1;
            ft_q     <= ft_d;
            pend_q   <= pend_d;
            // Copy reads the pre-edge shadow, so a same-cycle write lands in shadow only.
            if (copy) act_q <= shd_q;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_ok && (bus.wr_addr == SEL_W'(i))) shd_q[i] <= bus.wr_data;
            end
        end
    end

    assign bus.sel         = sel_q;
    assign bus.seg         = seg_q;
    assign bus.dec_en      = dec_en_q;
    assign bus.frame_tick  = ft_q;
    assign bus.commit_pend = pend_q;
endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Parametrised multiplexed 7-segment display controller for the board's common-anode digit bank, which is driven through a 3-to-8 decoder. Software or upstream logic writes per-digit codes into a shadow register file, and commits them atomically at a frame boundary. The block time-multiplexes NUM_DIGITS digits with configurable scan rate and 16-level PWM brightness. It supersedes the fixed 8-digit "0–7" scan demo as the display driver used by all board designs.

## Interface
- NUM_DIGITS, 8: digits scanned, 2..8.
- SEL_W, 3: width of digit-select output to decoder.
- SCAN_DIV, 8192: clk cycles per digit slot. Must be a multiple of 16 and ≥ 16.
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write strobe into shadow register file.
- wr_addr  in  SEL_W  digit index to write. Index 0 is the rightmost digit.
- wr_data  in  6  {blank, dp, hex[3:0]}.
- commit  in  1  one-cycle request to copy shadow to active at the next frame end.
- bright  in  4  brightness, 0 = 1/16 duty, 15 = full.
- commit_pend  out  1  commit requested and not yet applied.
- sel  out  SEL_W  current digit index to decoder.
- seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}.
- dec_en  out  1  decoder enable.
- frame_tick  out  1  one-cycle pulse in the last cycle of the last digit slot.

## Operation
- Prescaler `pcnt` counts 0..SCAN_DIV-1 and wraps.
  - When it wraps, digit index `dig` advances; it wraps from NUM_DIGITS-1 to 0.
  - frame_tick = (pcnt==SCAN_DIV-1) && (dig==NUM_DIGITS-1), registered so that it aligns with that cycle.
- Shadow file: NUM_DIGITS × 6 bits, written synchronously when wr_en is high.
  - A write with wr_addr ≥ NUM_DIGITS is ignored.
- Active file: NUM_DIGITS × 6 bits, drives the display only.
  - Copy occurs in the frame_tick cycle if commit_pend is high, or if commit is high in that same cycle.
  - The copy uses shadow contents from before that cycle's write. A same-cycle write lands in shadow only.
  - commit_pend is set by commit and cleared by the copy. A commit arriving during a pending commit has no further effect.
- Brightness: `bright` is latched into `bri_q` at pcnt==0.
  - Sub-slot index is s = pcnt / (SCAN_DIV/16).
  - Segments are lit while s ≤ bri_q; otherwise seg = 8'hFF.
- Decode of hex 0..F, as seg[6:0]: C0,F9,A4,B0,99,92,82,F8,80,98,88,83,C6,A1,86,8E (low 7 bits).
  - dp=1 clears seg[7].
  - blank=1 forces seg = 8'hFF regardless of dp.
- dec_en is 1 whenever out of reset.

## Timing
- Reset values:
  - pcnt=0, dig=0, sel=0, seg=8'hFF, dec_en=0, frame_tick=0, commit_pend=0, bri_q=0.
  - All shadow and active entries are {blank=1, dp=0, hex=0}.
- sel and seg are registered and change together, one cycle after dig/pcnt change. They never show a mismatched digit/segment pair.
- Slot period is exactly SCAN_DIV cycles. Frame period is NUM_DIGITS × SCAN_DIV cycles.
- A write becomes visible on seg at the start of the first slot after the commit-triggered copy (worst case: one frame plus one cycle after commit).
- A bright change takes effect at the next slot start. It never causes a mid-slot glitch.
- Reset asserted mid-frame immediately returns all state to reset values and discards a pending commit. After release, dec_en=1 and scanning restart from digit 0.

## Configuration
- SEG7_LZ_SUPPRESS_EN defined: leading-zero suppression is applied to the active file.
  - Scanning from index NUM_DIGITS-1 downward, each digit with hex==0 and dp==0 is treated as blank until the first digit that is non-zero, has dp set, or is explicitly non-blank with a non-zero value.
  - Digit 0 is never suppressed.
  - The suppression mask is recomputed combinationally from the active file.
- Not defined: every non-blank digit is displayed as written, and the mask logic is absent.

## Test plan
- Reset, then 3 frames with NUM_DIGITS=8, SCAN_DIV=16 → sel steps 0..7 every 16 cycles, seg=8'hFF throughout, frame_tick every 128 cycles.
- Write digits 0..7 = hex 0..7 (blank=0), commit, bright=15 → after the next frame_tick, seg per slot = C0,F9,A4,B0,99,92,82,F8.
- Write digit 2 = {0,1,4'hA} with no commit → display unchanged. Commit in the frame_tick cycle → digit 2 shows 8'h08 from the next frame; commit_pend is never seen high.
- bright=3, SCAN_DIV=64 → in each slot, seg is valid for cycles 0–15 and 8'hFF for cycles 16–63.
- With SEG7_LZ_SUPPRESS_EN, active = 0,0,0,0,0,1,0,0 (index 7..0) → indices 7..3 blank, index 2 shows F9, indices 1 and 0 show C0.
- Assert rst mid-slot with commit_pend=1 → all outputs return to reset values, commit_pend=0, and the old active contents are lost (display blank).
